// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the CDB request arbiter: sizing,
// state codes and station-ID arithmetic.
package cdb_arbiter_pkg;

  localparam int N_RS  = 8;
  localparam int ID_W  = 4;
  localparam int PTR_W = $clog2(N_RS);

  localparam logic [ID_W-1:0] ID_NONE = '0;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] GRANT   = 2'b01;
  localparam logic [1:0] RELEASE = 2'b10;

  // Station IDs are 1-based so that 0 can mean "no grant" on the bus.
  function automatic logic [ID_W-1:0] to_id(input logic [PTR_W-1:0] idx);
    return ID_W'(idx) + ID_W'(1);
  endfunction

  function automatic logic [N_RS-1:0] onehot(input logic [PTR_W-1:0] idx);
    return N_RS'(1) << idx;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    logic [PTR_W:0] sum;
    sum = {1'b0, idx} + (PTR_W+1)'(1);
    if (sum >= (PTR_W+1)'(N_RS)) sum = sum - (PTR_W+1)'(N_RS);
    return sum[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/grant bus between the reservation stations, the CDB and the
// confirmation decoder.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [N_RS-1:0] req;
  logic            ack;
  logic [ID_W-1:0] ID;
  logic            valid;
  logic            pending;

  modport master (input req, ack, output ID, valid, pending);
  modport slave  (output req, ack, input ID, valid, pending);
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate so ptr sits at bit 0, take the
// lowest set bit, then rotate the index back.
module rr_picker
  import cdb_arbiter_pkg::*;
(
  input  logic [N_RS-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  logic [2*N_RS-1:0] dbl;
  logic [N_RS-1:0]   rot;
  logic [PTR_W-1:0]  ridx;
  logic [PTR_W:0]    sum;

  // NOTE: every variable gets a default before any conditional write, so
  // no path leaves it holding its old value and no latch is inferred.
  always_comb begin
    dbl  = {req, req} >> ptr;
    rot  = dbl[N_RS-1:0];
    any  = |req;
    ridx = '0;
    for (int i = N_RS - 1; i >= 0; i--) begin
      if (rot[i]) ridx = PTR_W'(i);
    end
    sum = {1'b0, ridx} + {1'b0, ptr};
    if (sum >= (PTR_W+1)'(N_RS)) sum = sum - (PTR_W+1)'(N_RS);
    idx = sum[PTR_W-1:0];
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB broadcast arbiter: grants one station, holds it until the
// CDB acks, then waits for the winner to drop its request.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          CLK,
  input  logic          CLR,
  cdb_arbiter_if.master bus
);

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [ID_W-1:0]  id_r;
  logic             valid_r;

  logic             pick_any;
  logic [PTR_W-1:0] pick_idx;

  rr_picker u_picker (
    .req (bus.req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      id_r    <= ID_NONE;
      valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            win     <= pick_idx;
            id_r    <= to_id(pick_idx);
            valid_r <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          // ack takes priority over a simultaneous withdrawal.
          if (bus.ack) begin
            ptr     <= next_ptr(win);
            valid_r <= 1'b0;
            state   <= RELEASE;
          end else if (!bus.req[win]) begin
            id_r    <= ID_NONE;
            valid_r <= 1'b0;
            state   <= IDLE;
          end
        end
        RELEASE: begin
          // ID is kept so the registered decoder still confirms the winner.
          valid_r <= 1'b0;
          if (!bus.req[win]) begin
            id_r  <= ID_NONE;
            state <= IDLE;
          end
        end
        default: begin
          id_r    <= ID_NONE;
          valid_r <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ID      = id_r;
  assign bus.valid   = valid_r;
  assign bus.pending = |(bus.req & ~(valid_r ? onehot(win) : '0));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected grant IDs are queued with the
// stimulus and compared by a monitor on every new grant.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic CLK;
  logic CLR;
  int   n_vec;
  int   n_err;
  int   exp_q[$];
  logic prev_valid;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Grant monitor: each rising edge of valid consumes one expected ID.
  initial prev_valid = 1'b0;
  always @(negedge CLK) begin
    if (!CLR && bus.valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_grant: got ID %0d expected no grant", bus.ID);
      end else begin
        check("grant_id", 32'(bus.ID), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = bus.valid;
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    CLR     = 1'b1;
    bus.req = '0;
    bus.ack = 1'b0;
    tick(2);
    check("reset_id", 32'(bus.ID), 0);
    check("reset_valid", 32'(bus.valid), 0);
    check("reset_pending", 32'(bus.pending), 0);
    CLR = 1'b0;
    tick();

    // Single requester: grant, ack, hold ID in RELEASE, drop to IDLE.
    bus.req = 8'b0000_0100;
    exp_q.push_back(3);
    tick();
    check("single_valid", 32'(bus.valid), 1);
    check("single_id", 32'(bus.ID), 3);
    check("single_pending", 32'(bus.pending), 0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("release_valid", 32'(bus.valid), 0);
    check("release_id", 32'(bus.ID), 3);
    tick();
    check("release_hold_id", 32'(bus.ID), 3);
    bus.req = '0;
    tick();
    check("idle_id", 32'(bus.ID), 0);
    check("idle_valid", 32'(bus.valid), 0);

    // ack in IDLE is ignored; ptr=3 so all-ones picks station 4.
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("ack_idle_valid", 32'(bus.valid), 0);
    check("ack_idle_id", 32'(bus.ID), 0);
    bus.req = 8'hFF;
    exp_q.push_back(4);
    tick();
    check("ptr_after_release_id", 32'(bus.ID), 4);
    check("grant_pending", 32'(bus.pending), 1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    // RELEASE with all requests up: pending, but no new grant.
    check("release_pending", 32'(bus.pending), 1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("ack_release_valid", 32'(bus.valid), 0);
    check("ack_release_id", 32'(bus.ID), 4);
    tick(2);
    check("release_no_regrant", 32'(bus.valid), 0);
    check("release_still_id", 32'(bus.ID), 4);
    bus.req = '0;
    tick();
    check("release_exit_id", 32'(bus.ID), 0);

    // Withdrawal without ack leaves ptr=4, so 8'h30 re-grants station 5.
    bus.req = 8'h10;
    exp_q.push_back(5);
    tick();
    check("withdraw_grant_id", 32'(bus.ID), 5);
    bus.req = '0;
    tick();
    check("withdraw_valid", 32'(bus.valid), 0);
    check("withdraw_id", 32'(bus.ID), 0);
    bus.req = 8'h30;
    exp_q.push_back(5);
    tick();
    check("regrant_id", 32'(bus.ID), 5);
    check("regrant_pending", 32'(bus.pending), 1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.req = '0;
    tick();

    // Mid-grant reset: ptr is now 5, so all-ones grants station 6 first.
    bus.req = 8'hFF;
    exp_q.push_back(6);
    tick();
    @(negedge CLK);
    #1;
    CLR = 1'b1;
    #1;
    check("clr_async_id", 32'(bus.ID), 0);
    check("clr_async_valid", 32'(bus.valid), 0);
    tick();
    CLR = 1'b0;

    // Full rotation from ptr=0: 1..8 then 1 again.
    for (int k = 0; k < 9; k++) begin
      bus.req = 8'hFF;
      exp_q.push_back((k % 8) + 1);
      tick();
      check("rr_valid", 32'(bus.valid), 1);
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      bus.req = 8'hFF & ~(8'h01 << (k % 8));
      tick();
      check("rr_idle_id", 32'(bus.ID), 0);
    end

    // ptr=1: station 8 wins before station 1.
    bus.req = 8'b1000_0001;
    exp_q.push_back(8);
    exp_q.push_back(1);
    tick();
    check("wrap_id", 32'(bus.ID), 8);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.req = 8'b0000_0001;
    tick(2);
    check("wrap_second_id", 32'(bus.ID), 1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.req = '0;
    tick(3);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
